// File: rtl/mult8_seq_sched_pkg.sv
// Shared types and helpers for the sequential 8x8 multiplier scheduler.
// Quadrant codes: bit 1 selects the A half, bit 0 selects the B half.
package mult_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Q_LL = 3'd1,
        S_Q_LH = 3'd2,
        S_Q_HL = 3'd3,
        S_Q_HH = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [1:0] KSEL_EXACT = 2'b00;
    localparam logic [1:0] KSEL_N2    = 2'b01;
    localparam logic [1:0] KSEL_R1    = 2'b10;

    localparam logic [1:0] QUAD_LL = 2'd0;
    localparam logic [1:0] QUAD_LH = 2'd1;
    localparam logic [1:0] QUAD_HL = 2'd2;
    localparam logic [1:0] QUAD_HH = 2'd3;

    localparam int unsigned SHIFT_LL = 0;
    localparam int unsigned SHIFT_LH = 4;
    localparam int unsigned SHIFT_HL = 4;
    localparam int unsigned SHIFT_HH = 8;

    // Returns {a_nibble, b_nibble} for the given quadrant.
    function automatic logic [7:0] nib_sel(input logic [1:0] quad,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [3:0] an;
        logic [3:0] bn;
        an = quad[1] ? a[7:4] : a[3:0];
        bn = quad[0] ? b[7:4] : b[3:0];
        return {an, bn};
    endfunction

    function automatic logic [1:0] cfg_sel(input logic [1:0] quad,
                                           input logic [7:0] cfg);
        logic [1:0] s;
        case (quad)
            QUAD_LL: s = cfg[1:0];
            QUAD_LH: s = cfg[3:2];
            QUAD_HL: s = cfg[5:4];
            default: s = cfg[7:6];
        endcase
        return s;
    endfunction

    function automatic int unsigned quad_shift(input logic [1:0] quad);
        int unsigned sh;
        case (quad)
            QUAD_LL: sh = SHIFT_LL;
            QUAD_LH: sh = SHIFT_LH;
            QUAD_HL: sh = SHIFT_HL;
            default: sh = SHIFT_HH;
        endcase
        return sh;
    endfunction

    function automatic state_t quad_state(input logic [1:0] quad);
        state_t s;
        case (quad)
            QUAD_LL: s = S_Q_LL;
            QUAD_LH: s = S_Q_LH;
            QUAD_HL: s = S_Q_HL;
            default: s = S_Q_HH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mult8_seq_sched_kernel_sel.sv
// 4x4 kernel slot: exact, N2 (two LSBs forced high) and R1 (a*(b+1)) kernels
// behind a runtime select; code 11 falls back to exact.
module exact_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module N2_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] full;
    assign full = {4'b0000, a} * {4'b0000, b};
    assign p    = {full[7:2], 2'b11};
endmodule

module R1_4x4_mul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    logic [7:0] full;
    assign full = {4'b0000, a} * {4'b0000, b};
    assign p    = full + {4'b0000, a};
endmodule

module mult4_kernel_sel
    import mult_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] sel,
    output logic [7:0] p
);
    logic [7:0] p_ex;
    logic [7:0] p_n2;
    logic [7:0] p_r1;

    exact_4x4_mul u_exact (.a(a), .b(b), .p(p_ex));
    N2_4x4_mul    u_n2    (.a(a), .b(b), .p(p_n2));
    R1_4x4_mul    u_r1    (.a(a), .b(b), .p(p_r1));

    always_comb begin
        p = p_ex;
        case (sel)
            KSEL_N2: p = p_n2;
            KSEL_R1: p = p_r1;
            default: p = p_ex;
        endcase
    end
endmodule

// File: rtl/mult8_seq_sched.sv
// Sequential 8x8 multiplier: one 4x4 kernel slot time-shared over the four
// nibble quadrants, with valid/ready handshakes on operand and result.
module mult8_seq_sched #(
    parameter int SKIP_ZERO = 0,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    input  logic [7:0]       cfg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] R,
    output logic             busy
);
    import mult_seq_pkg::*;

    if (ACC_W != 16) begin : g_bad_acc_w
        $error("mult8_seq_sched: ACC_W must be 16");
    end

    localparam bit SKIP_EN = (SKIP_ZERO != 0);

    state_t           state_q, state_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [7:0]       cfg_q, cfg_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] r_q, r_d;

    logic [1:0]       quad;
    logic [7:0]       nibs;
    logic [1:0]       k_sel;
    logic [7:0]       prod8;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] acc_sum;

    // First quadrant at or after index 'from' that still has work, else DONE.
    function automatic state_t next_live(input int unsigned from,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        state_t      nxt;
        int unsigned q;
        logic [7:0]  nb;
        nxt = S_DONE;
        for (int unsigned i = 0; i < 4; i++) begin
            q  = 3 - i;
            nb = nib_sel(q[1:0], a, b);
            if (q >= from && !(SKIP_EN && (nb[7:4] == 4'd0 || nb[3:0] == 4'd0)))
                nxt = quad_state(q[1:0]);
        end
        return nxt;
    endfunction

    mult4_kernel_sel u_kernel (
        .a   (nibs[7:4]),
        .b   (nibs[3:0]),
        .sel (k_sel),
        .p   (prod8)
    );

    always_comb begin
        quad = QUAD_LL;
        case (state_q)
            S_Q_LH:  quad = QUAD_LH;
            S_Q_HL:  quad = QUAD_HL;
            S_Q_HH:  quad = QUAD_HH;
            default: quad = QUAD_LL;
        endcase
        nibs    = nib_sel(quad, a_q, b_q);
        k_sel   = cfg_sel(quad, cfg_q);
        term    = ACC_W'(prod8) << quad_shift(quad);
        acc_sum = acc_q + term;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cfg_d   = cfg_q;
        acc_d   = acc_q;
        r_d     = r_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    cfg_d   = cfg;
                    acc_d   = '0;
                    state_d = next_live(0, A, B);
                    if (state_d == S_DONE) r_d = '0;
                end
            end
            S_Q_LL, S_Q_LH, S_Q_HL, S_Q_HH: begin
                acc_d   = acc_sum;
                state_d = next_live(32'(quad) + 1, a_q, b_q);
                if (state_d == S_DONE) r_d = acc_sum;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cfg_q   <= '0;
            acc_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cfg_q   <= cfg_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign R         = r_q;

endmodule
